// File: rtl/cluster_accuracy_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : cluster_accuracy_monitor_if
// Purpose  : Vector handshake bundle between the output-bit modules plus the
//            golden reference (master) and the accuracy monitor (slave).
// Revision : 1.0  initial release
// ============================================================================
interface cluster_accuracy_monitor_if #(
  parameter int NBITS = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] pred;
  logic [NBITS-1:0] gold;

  modport master (
    output in_valid,
    output pred,
    output gold,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  pred,
    input  gold,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/cluster_accuracy_monitor.sv
`default_nettype none
// ============================================================================
// Module   : cluster_accuracy_monitor
// Purpose  : Scores predicted output words against golden words, counting
//            tests, failing tests and capturing the first failure.
//            Optional MONITOR_BITMASK_EN adds a sticky per-bit fail_mask.
// Revision : 1.0  initial release
// ============================================================================
module cluster_accuracy_monitor #(
  parameter int NBITS       = 128,
  parameter int CNT_W       = 32,
  parameter int TEST_TARGET = 1000000,
  parameter int IDX_W       = $clog2(NBITS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  cluster_accuracy_monitor_if.slave mon,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [CNT_W-1:0]          test_cnt,
  output logic [CNT_W-1:0]          err_cnt,
  output logic [CNT_W-1:0]          first_fail_test,
  output logic [IDX_W-1:0]          first_fail_bit,
  output logic                      fail_seen
`ifdef MONITOR_BITMASK_EN
  ,
  output logic [NBITS-1:0]          fail_mask
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_target = CNT_W'(TEST_TARGET);
  localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_acc_cnt;
  logic [CNT_W-1:0] r_test_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_ff_test;
  logic [IDX_W-1:0] r_ff_bit;
  logic             r_fail_seen;
  logic             r_v1;
  logic             r_v2;
  logic [NBITS-1:0] r_diff;
  logic             r_mism;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx;
  logic             w_run;
  logic             w_ready;
  logic             w_xfer;
`ifdef MONITOR_BITMASK_EN
  logic [NBITS-1:0] r_diff2;
  logic [NBITS-1:0] r_mask;
`endif

  assign w_run        = (r_state == S_RUN);
  assign w_ready      = w_run && !abort && (r_acc_cnt < c_target);
  assign w_xfer       = mon.in_valid && w_ready;
  assign mon.in_ready = w_ready;

  // Lowest set bit wins: scan from the top so lower indices overwrite.
  always_comb begin
    w_idx = '0;
    for (int i = NBITS - 1; i >= 0; i--) begin
      if (r_diff[i]) begin
        w_idx = IDX_W'(i);
      end
    end
  end

  // Data path carries no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    r_diff  <= mon.pred ^ mon.gold;
    r_mism  <= |r_diff;
    r_idx   <= w_idx;
`ifdef MONITOR_BITMASK_EN
    r_diff2 <= r_diff;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc_cnt   <= '0;
      r_test_cnt  <= '0;
      r_err_cnt   <= '0;
      r_ff_test   <= '0;
      r_ff_bit    <= '0;
      r_fail_seen <= 1'b0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
`ifdef MONITOR_BITMASK_EN
      r_mask      <= '0;
`endif
    end else begin
      r_v1 <= w_xfer;
      r_v2 <= r_v1;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_acc_cnt   <= '0;
            r_test_cnt  <= '0;
            r_err_cnt   <= '0;
            r_ff_test   <= '0;
            r_ff_bit    <= '0;
            r_fail_seen <= 1'b0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
`ifdef MONITOR_BITMASK_EN
            r_mask      <= '0;
`endif
          end
        end
        S_RUN: begin
          if (abort) begin
            // In-flight vectors are dropped, including one at stage 2 now.
            r_state <= S_DONE;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
          end else begin
            if (w_xfer) begin
              r_acc_cnt <= r_acc_cnt + c_one;
            end
            if (r_v2) begin
              r_test_cnt <= r_test_cnt + c_one;
`ifdef MONITOR_BITMASK_EN
              r_mask     <= r_mask | r_diff2;
`endif
              if (r_mism) begin
                r_err_cnt <= r_err_cnt + c_one;
                if (!r_fail_seen) begin
                  r_ff_test   <= r_test_cnt;
                  r_ff_bit    <= r_idx;
                  r_fail_seen <= 1'b1;
                end
              end
            end
            if (r_test_cnt == c_target) begin
              r_state <= S_DONE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy            = (r_state == S_RUN);
  assign done            = (r_state == S_DONE);
  assign pass            = done && (r_err_cnt == '0);
  assign test_cnt        = r_test_cnt;
  assign err_cnt         = r_err_cnt;
  assign first_fail_test = r_ff_test;
  assign first_fail_bit  = r_ff_bit;
  assign fail_seen       = r_fail_seen;
`ifdef MONITOR_BITMASK_EN
  assign fail_mask       = r_mask;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cluster_accuracy_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cluster_accuracy_monitor
// Purpose  : Self-checking bench; per-run expectations are queued when a run
//            is issued and popped by monitors when done rises.
// Revision : 1.0  initial release
// ============================================================================
module tb_cluster_accuracy_monitor;
  localparam int NB = 16;
  localparam int CW = 32;
  localparam int IW = 4;
  localparam int NBIG = 1000;

  typedef struct {
    logic [CW-1:0] tc;
    logic [CW-1:0] ec;
    logic [CW-1:0] fft;
    logic [IW-1:0] ffb;
    logic          fs;
    logic          ps;
    logic [NB-1:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start_a, abort_a, start_b, abort_b;
  logic busy_a, done_a, pass_a, fs_a, busy_b, done_b, pass_b, fs_b;
  logic [CW-1:0] tc_a, ec_a, fft_a, tc_b, ec_b, fft_b;
  logic [IW-1:0] ffb_a, ffb_b;
`ifdef MONITOR_BITMASK_EN
  logic [NB-1:0] mask_a, mask_b;
`endif

  cluster_accuracy_monitor_if #(.NBITS(NB)) ifa ();
  cluster_accuracy_monitor_if #(.NBITS(NB)) ifb ();

  cluster_accuracy_monitor #(.NBITS(NB), .CNT_W(CW), .TEST_TARGET(8), .IDX_W(IW)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .mon(ifa),
    .busy(busy_a), .done(done_a), .pass(pass_a), .test_cnt(tc_a), .err_cnt(ec_a),
    .first_fail_test(fft_a), .first_fail_bit(ffb_a), .fail_seen(fs_a)
`ifdef MONITOR_BITMASK_EN
    , .fail_mask(mask_a)
`endif
  );

  cluster_accuracy_monitor #(.NBITS(NB), .CNT_W(CW), .TEST_TARGET(NBIG), .IDX_W(IW)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .mon(ifb),
    .busy(busy_b), .done(done_b), .pass(pass_b), .test_cnt(tc_b), .err_cnt(ec_b),
    .first_fail_test(fft_b), .first_fail_bit(ffb_b), .fail_seen(fs_b)
`ifdef MONITOR_BITMASK_EN
    , .fail_mask(mask_b)
`endif
  );

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [CW-1:0] tc, input logic [CW-1:0] ec,
                              input logic [CW-1:0] fft, input logic [IW-1:0] ffb,
                              input logic fs, input logic [NB-1:0] m);
    exp_t e;
    e.tc = tc; e.ec = ec; e.fft = fft; e.ffb = ffb; e.fs = fs;
    e.ps = (ec == '0); e.mask = m;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run-result monitors: compare on each rising edge of done.
  initial begin
    logic pd;
    exp_t e;
    pd = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (done_a && !pd) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_done", 64'(done_a), 64'(0));
        end else begin
          e = qa.pop_front();
          chk("a_test_cnt", 64'(tc_a), 64'(e.tc));
          chk("a_err_cnt", 64'(ec_a), 64'(e.ec));
          chk("a_first_fail_test", 64'(fft_a), 64'(e.fft));
          chk("a_first_fail_bit", 64'(ffb_a), 64'(e.ffb));
          chk("a_fail_seen", 64'(fs_a), 64'(e.fs));
          chk("a_pass", 64'(pass_a), 64'(e.ps));
          chk("a_busy_in_done", 64'(busy_a), 64'(0));
`ifdef MONITOR_BITMASK_EN
          chk("a_fail_mask", 64'(mask_a), 64'(e.mask));
`endif
        end
      end
      pd = done_a;
    end
  end

  initial begin
    logic pd;
    exp_t e;
    pd = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (done_b && !pd) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_done", 64'(done_b), 64'(0));
        end else begin
          e = qb.pop_front();
          chk("b_test_cnt", 64'(tc_b), 64'(e.tc));
          chk("b_err_cnt", 64'(ec_b), 64'(e.ec));
          chk("b_first_fail_test", 64'(fft_b), 64'(e.fft));
          chk("b_first_fail_bit", 64'(ffb_b), 64'(e.ffb));
          chk("b_fail_seen", 64'(fs_b), 64'(e.fs));
          chk("b_pass", 64'(pass_b), 64'(e.ps));
`ifdef MONITOR_BITMASK_EN
          chk("b_fail_mask", 64'(mask_b), 64'(e.mask));
`endif
        end
      end
      pd = done_b;
    end
  end

  // Present a vector and hold it until the transfer edge.
  task automatic send_a(input logic [NB-1:0] p, input logic [NB-1:0] g);
    int k;
    ifa.in_valid = 1'b1; ifa.pred = p; ifa.gold = g;
    k = 0;
    while (!ifa.in_ready && k < 20) begin tick(); k++; end
    if (k == 20) chk("a_send_timeout", 64'(ifa.in_ready), 64'(1));
    else tick();
  endtask

  task automatic send_b(input logic [NB-1:0] p, input logic [NB-1:0] g);
    int k;
    ifb.in_valid = 1'b1; ifb.pred = p; ifb.gold = g;
    k = 0;
    while (!ifb.in_ready && k < 20) begin tick(); k++; end
    if (k == 20) chk("b_send_timeout", 64'(ifb.in_ready), 64'(1));
    else tick();
  endtask

  task automatic start_run_a();
    start_a = 1'b1; tick(); start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int bound);
    int k;
    k = 0;
    while (!done_a && k < bound) begin tick(); k++; end
    chk("a_done_wait", 64'(done_a), 64'(1));
  endtask

  logic [NB-1:0] vp[NBIG];
  logic [NB-1:0] vd[NBIG];

  initial begin
    logic [NB-1:0] v, d, m;
    int xfers, ec, fft, ffb, k;
    logic fs;

    rst = 1'b1; start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
    ifa.in_valid = 0; ifa.pred = '0; ifa.gold = '0;
    ifb.in_valid = 0; ifb.pred = '0; ifb.gold = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy_a), 64'(0));
    chk("rst_done", 64'(done_a), 64'(0));
    chk("rst_pass", 64'(pass_a), 64'(0));
    chk("rst_test_cnt", 64'(tc_a), 64'(0));
    chk("rst_fail_seen", 64'(fs_a), 64'(0));
    chk("rst_in_ready", 64'(ifa.in_ready), 64'(0));
    rst = 1'b0;
    tick();

    // 1: eight clean vectors back-to-back; done three clocks after the last.
    qa.push_back(mk(8, 0, 0, 0, 1'b0, 16'h0000));
    start_run_a();
    for (int i = 0; i < 8; i++) begin
      v = NB'(i * 4369) ^ 16'h5a5a;
      send_a(v, v);
    end
    ifa.in_valid = 1'b0;
    tick();
    chk("t1_done_plus1", 64'(done_a), 64'(0));
    tick();
    chk("t1_done_plus2", 64'(done_a), 64'(0));
    chk("t1_cnt_plus2", 64'(tc_a), 64'(8));
    tick();
    chk("t1_done_plus3", 64'(done_a), 64'(1));

    // 2: vectors 2 and 5 fail at bits {9,3} and {0}.
    qa.push_back(mk(8, 2, 2, 3, 1'b1, 16'h0209));
    start_run_a();
    for (int i = 0; i < 8; i++) begin
      d = (i == 2) ? 16'h0208 : ((i == 5) ? 16'h0001 : 16'h0000);
      v = 16'hc3a0 + NB'(i * 7);
      send_a(v, v ^ d);
    end
    ifa.in_valid = 1'b0;
    wait_done_a(10);

    // 3: valid held high well past the target.
    qa.push_back(mk(8, 0, 0, 0, 1'b0, 16'h0000));
    start_run_a();
    xfers = 0;
    ifa.in_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      ifa.pred = NB'($urandom);
      ifa.gold = ifa.pred;
      if (xfers >= 8) chk("t3_ready_low", 64'(ifa.in_ready), 64'(0));
      if (ifa.in_ready) xfers++;
      tick();
    end
    ifa.in_valid = 1'b0;
    chk("t3_transfers", 64'(xfers), 64'(8));
    wait_done_a(10);

    // 4: abort (with a simultaneous start) after 4 transfers, 2 in flight.
    qa.push_back(mk(2, 1, 0, 5, 1'b1, 16'h0020));
    start_run_a();
    for (int i = 0; i < 4; i++) begin
      v = 16'h0f0f + NB'(i);
      send_a(v, (i == 0) ? (v ^ 16'h0020) : v);
    end
    ifa.in_valid = 1'b0;
    abort_a = 1'b1; start_a = 1'b1;
    tick();
    abort_a = 1'b0; start_a = 1'b0;
    chk("t4_done_next", 64'(done_a), 64'(1));
    for (int i = 0; i < 5; i++) tick();
    chk("t4_hold_test_cnt", 64'(tc_a), 64'(2));
    chk("t4_hold_err_cnt", 64'(ec_a), 64'(1));

    // 5: asynchronous reset mid-run, then a fresh run from IDLE.
    start_run_a();
    for (int i = 0; i < 3; i++) send_a(16'h1234, 16'h1234);
    chk("t5_pre_rst_cnt", 64'(tc_a), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", 64'(busy_a), 64'(0));
    chk("t5_rst_test_cnt", 64'(tc_a), 64'(0));
    chk("t5_rst_in_ready", 64'(ifa.in_ready), 64'(0));
    ifa.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("t5_idle_done", 64'(done_a), 64'(0));
    qa.push_back(mk(8, 1, 7, 15, 1'b1, 16'h8000));
    start_run_a();
    for (int i = 0; i < 8; i++) begin
      v = 16'h3c3c ^ NB'(i);
      send_a(v, (i == 7) ? (v ^ 16'h8000) : v);
    end
    ifa.in_valid = 1'b0;
    wait_done_a(10);
    start_run_a();
    chk("t5_clr_test_cnt", 64'(tc_a), 64'(0));
    chk("t5_clr_first_fail", 64'(fft_a), 64'(0));
    chk("t5_clr_fail_seen", 64'(fs_a), 64'(0));
    chk("t5_run_busy", 64'(busy_a), 64'(1));
    qa.push_back(mk(0, 0, 0, 0, 1'b0, 16'h0000));
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    tick();

    // 6: 1000 vectors, random gaps and random single-bit errors.
    ec = 0; fft = 0; ffb = 0; fs = 1'b0; m = '0;
    for (int i = 0; i < NBIG; i++) begin
      vp[i] = NB'($urandom);
      if ($urandom_range(9, 0) == 0) begin
        k = int'($urandom_range(NB - 1, 0));
        vd[i] = NB'(1) << k;
        if (!fs) begin fs = 1'b1; fft = i; ffb = k; end
        ec++;
        m = m | vd[i];
      end else begin
        vd[i] = '0;
      end
    end
    qb.push_back(mk(CW'(NBIG), CW'(ec), CW'(fft), IW'(ffb), fs, m));
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int i = 0; i < NBIG; i++) begin
      while ($urandom_range(1, 0) == 0) begin
        ifb.in_valid = 1'b0; ifb.pred = NB'($urandom); ifb.gold = NB'($urandom);
        tick();
      end
      send_b(vp[i], vp[i] ^ vd[i]);
    end
    ifb.in_valid = 1'b0;
    k = 0;
    while (!done_b && k < 20) begin tick(); k++; end
    chk("b_done_wait", 64'(done_b), 64'(1));
    tick(); tick();
    chk("qa_drained", 64'(qa.size()), 64'(0));
    chk("qb_drained", 64'(qb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
